// File: rtl/sprite_compositor.sv
// sprite_compositor: layered sprite/bar/ground pixel compositor with per-frame shadow latch,
// two-stage pixel pipeline, idle blink and per-frame player/obstacle collision flag.
module sprite_compositor #(
  parameter int N_OBJ        = 4,
  parameter int X_W          = 12,
  parameter int Y_W          = 11,
  parameter int OBJ_XW       = 9,
  parameter int X_SCALE      = 10,
  parameter int HALF_W       = 50,
  parameter int HALF_H       = 50,
  parameter int GROUND_Y     = 980,
  parameter int BAR_STEP     = 15,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              mode,
  input  logic [N_OBJ*OBJ_XW-1:0] obj_x,
  input  logic [N_OBJ*Y_W-1:0]    obj_y,
  input  logic [OBJ_XW-1:0]       player_x,
  input  logic [Y_W-1:0]          player_y,
  input  logic [X_W-1:0]          sx,
  input  logic [Y_W-1:0]          sy,
  input  logic                    de,
  input  logic                    frame_start,
  input  logic [7:0]              score,
  input  logic [7:0]              best_score,
  output logic                    collision,
  output logic [3:0]              Rout,
  output logic [3:0]              Gout,
  output logic [3:0]              Bout
);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, PAUSE = 2'd2} mode_t;

  // Left edges are kept one bit wider too, so a far-right centre cannot wrap onto the screen.
  function automatic logic [X_W:0] x_lo(input logic [OBJ_XW-1:0] x);
    int c;
    c = int'(x) * X_SCALE;
    return (X_W+1)'(c > HALF_W ? c - HALF_W : 0);
  endfunction
  function automatic logic [X_W:0] x_hi(input logic [OBJ_XW-1:0] x);
    return (X_W+1)'(int'(x) * X_SCALE + HALF_W);
  endfunction
  function automatic logic [Y_W:0] y_lo(input logic [Y_W-1:0] y);
    return (Y_W+1)'(int'(y) > HALF_H ? int'(y) - HALF_H : 0);
  endfunction
  function automatic logic [Y_W:0] y_hi(input logic [Y_W-1:0] y);
    return (Y_W+1)'(int'(y) + HALF_H);
  endfunction

  mode_t          mode_s, m1;
  logic [X_W:0]   o_l [N_OBJ];
  logic [X_W:0]   o_r [N_OBJ];
  logic [Y_W:0]   o_t [N_OBJ];
  logic [Y_W:0]   o_b [N_OBJ];
  logic [X_W:0]   p_l, p_r;
  logic [Y_W:0]   p_t, p_b;
  logic [7:0]     score_s, best_s;
  logic [BW-1:0]  cnt;
  logic           phase, acc;
  logic           p_hit, o_hit, sb_hit, bb_hit, g_hit;
  logic           de1, p1, o1, sb1, bb1, g1;
  logic [11:0]    play_rgb, rgb_n;
  logic [X_W:0]   sxe;
  logic [Y_W:0]   sye;
  logic [15:0]    sx16, sb_end, bb_end;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mode_s  <= IDLE;
      score_s <= '0;
      best_s  <= '0;
      p_l <= '0; p_r <= '0; p_t <= '0; p_b <= '0;
      for (int i = 0; i < N_OBJ; i++) begin
        o_l[i] <= '0; o_r[i] <= '0; o_t[i] <= '0; o_b[i] <= '0;
      end
    end else if (frame_start) begin
      mode_s  <= (mode == 2'd3) ? IDLE : mode_t'(mode);
      score_s <= score;
      best_s  <= best_score;
      p_l <= x_lo(player_x); p_r <= x_hi(player_x);
      p_t <= y_lo(player_y); p_b <= y_hi(player_y);
      for (int i = 0; i < N_OBJ; i++) begin
        o_l[i] <= x_lo(obj_x[i*OBJ_XW +: OBJ_XW]);
        o_r[i] <= x_hi(obj_x[i*OBJ_XW +: OBJ_XW]);
        o_t[i] <= y_lo(obj_y[i*Y_W +: Y_W]);
        o_b[i] <= y_hi(obj_y[i*Y_W +: Y_W]);
      end
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (mode_s != IDLE) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (frame_start) begin
      cnt   <= (cnt == BW'(BLINK_FRAMES-1)) ? '0 : cnt + 1'b1;
      phase <= (cnt == BW'(BLINK_FRAMES-1)) ? ~phase : phase;
    end

  assign sxe    = {1'b0, sx};
  assign sye    = {1'b0, sy};
  assign sx16   = 16'(sx);
  assign sb_end = 16'd30 + 16'(BAR_STEP) * {8'd0, score_s};
  assign bb_end = 16'd50 + 16'(BAR_STEP) * {8'd0, best_s};
  assign p_hit  = sxe >= p_l && sxe <= p_r && sye >= p_t && sye <= p_b;
  assign sb_hit = sy >= Y_W'(30) && sy <= Y_W'(60) && sx16 >= 16'd30 && sx16 <= sb_end;
  assign bb_hit = sy >= Y_W'(300) && sy <= Y_W'(330) && sx16 >= 16'd50 && sx16 <= bb_end && phase;
  assign g_hit  = sy >= Y_W'(GROUND_Y);

  always_comb begin
    o_hit = 1'b0;
    for (int i = 0; i < N_OBJ; i++)
      o_hit = o_hit | (sxe >= o_l[i] && sxe <= o_r[i] && sye >= o_t[i] && sye <= o_b[i]);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {de1, p1, o1, sb1, bb1, g1} <= '0;
      m1 <= IDLE;
    end else begin
      {de1, p1, o1, sb1, bb1, g1} <= {de, p_hit, o_hit, sb_hit, bb_hit, g_hit};
      m1 <= mode_s;
    end

  // A hit landing with frame_start belongs to the frame that is just beginning.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc       <= 1'b0;
      collision <= 1'b0;
    end else begin
      acc       <= (frame_start ? 1'b0 : acc) | (de1 & p1 & o1 & (mode_s == PLAY));
      collision <= frame_start ? acc : collision;
    end

  always_comb begin
    play_rgb = p1 ? 12'h00F : o1 ? 12'hF00 : sb1 ? 12'hFFF : g1 ? 12'h0F0 : 12'h000;
    rgb_n    = !de1         ? 12'h000 :
               m1 == PLAY   ? play_rgb :
               m1 == PAUSE  ? (play_rgb >> 1) & 12'h777 :
               bb1          ? 12'hFFF : 12'h000;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {Rout, Gout, Bout} <= '0;
    else        {Rout, Gout, Bout} <= rgb_n;
endmodule
